fp_add_align: RTL and testbench
===============================

# fp_add_align

Pre-alignment stage of the floating-point add/subtract path: accepts two IEEE-754 single-precision operands plus an add/subtract select and produces the larger-magnitude operand, the aligned smaller operand, the common exponent, the effective operation and special-case flags. Exponent difference uses a 9-bit subtract, with bit 8 as the borrow/sign. Sits directly upstream of the mantissa add/normalize stage, which consumes its outputs through a valid/ready handshake.

## Interface
- EXP_W, 8, exponent width; only the default is verified.
- MAN_W, 23, stored fraction width; only the default is verified.
- i_clk  input  1  clock; all state on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  stage can accept; combinational.
- i_a, i_b  input  32  operands.
- i_sub  input  1  1 = a − b, 0 = a + b.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts.
- o_sign  output  1  sign of larger-magnitude operand, after applying i_sub to b.
- o_exp  output  8  common (larger) effective exponent.
- o_mant_l  output  27  larger mantissa: hidden bit at [26], fraction at [25:3], G/R/S [2:0] = 0.
- o_mant_s  output  27  smaller mantissa, right-shifted, sticky ORed into [0].
- o_eff_sub  output  1  effective subtraction = sign_a ^ sign_b ^ i_sub.
- o_nan, o_inf, o_zero  output  1 each  special-case flags.

## Operation
- Unpack: hidden bit = (exp != 0). Effective exponent = 1 when the stored exponent is 0, so subnormals are handled.
- Swap: compare {exp, frac} of a and b as unsigned values. If b is larger, b becomes the L operand. On equality, a is L.
- o_sign = sign of L, where b's sign is taken as sign_b ^ i_sub.
- Shift amount d = exp_L − exp_S. It is computed as a 9-bit subtract of zero-extended exponents; bit 8 = 1 selects the swap.
- Alignment: o_mant_s = mant_S >> d. The sticky bit is the OR of every bit shifted out. For d ≥ 27, o_mant_s = {26'b0, (mant_S != 0)}.
- Specials:
  - o_nan = either operand is NaN, or both operands are Inf and o_eff_sub = 1.
  - o_inf = any Inf operand and !o_nan; o_sign is then the Inf operand's effective sign.
  - o_zero = both operands are ±0.
  - When any flag is set, the data outputs are still driven by the normal datapath and are don't-care downstream.

## Timing
- Two-stage pipeline.
  - S1 registers: unpack, swap and d.
  - S2 registers: the shifter output.
- Latency: 2 cycles from an accepted input to o_valid. Throughput: 1 operation per cycle.
- Global advance = !o_valid || i_ready. o_ready = advance. Both stages load only when advance = 1.
- Input is accepted when i_valid && o_ready.
- While o_valid && !i_ready, all outputs hold stable and nothing is dropped or duplicated.
- Bubbles propagate: an S1 valid bit of 0 moves into S2 as o_valid = 0.
- Reset: asynchronous.
  - o_valid, the S1 valid bit and all data/flag outputs go to 0 immediately.
  - An in-flight operation is discarded.
  - o_ready = 1 after reset.
- i_valid asserted while o_ready = 0: the input is not captured and the upstream block must hold it.

## Structure
- Shared FPU package holds:
  - FP32 field widths and positions: sign 31, exp 30:23, frac 22:0.
  - EXP_MAX = 8'hFF.
  - Aligned mantissa width = 27.
  - A packed struct for the unpacked operand (sign, exp, mant).
- One sub-module, fp_align_shift:
  - Combinational 27-bit right shifter with sticky.
  - Inputs: mant[23:0] and d[8:0]. Output: [26:0].
  - Instantiated in S2.

## Test plan
- 0x3F800000 + 0x3F800000, i_sub = 0 → after 2 cycles: o_exp = 0x7F, o_mant_l = o_mant_s = 0x4000000, o_eff_sub = 0, o_sign = 0.
- 0x3F800000 − 0x3FC00000 → swap: o_mant_l = 0x6000000, o_mant_s = 0x4000000, o_sign = 1, o_eff_sub = 1, o_exp = 0x7F.
- 0x3F800000 + 0x3D800001 (d = 4) → o_mant_s = 0x0400001, with the sticky bit set. 0x3F800000 + 0x30800000 (d = 30) → o_mant_s = 0x0000001.
- 0x7F800000 − 0x7F800000 → o_nan = 1. 0x7F800000 + 0x3F800000 → o_inf = 1, o_nan = 0. 0x00000000 + 0x80000000 → o_zero = 1.
- Three back-to-back operations with i_ready = 0 for cycles 3–5:
  - o_valid stays high and the outputs stay stable.
  - o_ready = 0 while stalled.
  - All three results emerge in order and exactly once.
- Assert i_reset mid-stream with two operations in flight → o_valid = 0 asynchronously. After release, o_valid stays 0 until a new input has been accepted and 2 cycles have passed.

Source files
------------

// File: rtl/fp_add_align_pkg.sv
// Shared FP32 field layout, alignment widths and operand unpack helpers
// for the add/subtract pre-alignment stage.
package fp_add_align_pkg;

    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_FRAC_MSB = 22;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MAN_W    = 23;
    localparam int ALIGN_W     = 27;   // hidden + fraction + guard/round/sticky
    localparam int DIFF_W      = 9;    // exponent difference incl. borrow bit

    localparam logic [FP_EXP_W-1:0] EXP_MAX = 8'hFF;

    // Unpacked operand: effective exponent and mantissa with hidden bit
    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W:0]   mant;
    } fp_unpacked_t;

    // Stage-1 payload: ordered operands plus shift amount and flags
    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W:0]   mant_l;
        logic [FP_MAN_W:0]   mant_s;
        logic [DIFF_W-1:0]   d;
        logic                eff_sub;
        logic                nan;
        logic                inf;
        logic                zero;
    } s1_t;

    // Stage-2 payload: what the downstream adder consumes
    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [ALIGN_W-1:0]  mant_l;
        logic [ALIGN_W-1:0]  mant_s;
        logic                eff_sub;
        logic                nan;
        logic                inf;
        logic                zero;
    } s2_t;

    // Subnormals take effective exponent 1 and no hidden bit
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x, input logic flip);
        fp_unpacked_t u;
        logic         norm;
        norm   = (x[FP_EXP_MSB:FP_EXP_LSB] != 8'h00);
        u.sign = x[FP_SIGN_BIT] ^ flip;
        u.exp  = norm ? x[FP_EXP_MSB:FP_EXP_LSB] : 8'h01;
        u.mant = {norm, x[FP_FRAC_MSB:0]};
        return u;
    endfunction

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[FP_EXP_MSB:FP_EXP_LSB] == EXP_MAX) && (x[FP_FRAC_MSB:0] != 23'h000000);
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] x);
        return (x[FP_EXP_MSB:FP_EXP_LSB] == EXP_MAX) && (x[FP_FRAC_MSB:0] == 23'h000000);
    endfunction

    function automatic logic fp_is_zero(input logic [31:0] x);
        return (x[FP_EXP_MSB:0] == 31'h00000000);
    endfunction

endpackage

// File: rtl/fp_add_align_if.sv
// Operand-in / aligned-result-out handshake bundle of the pre-alignment stage.
interface fp_add_align_if;
    import fp_add_align_pkg::*;

    logic               i_valid;
    logic               o_ready;
    logic [31:0]        i_a;
    logic [31:0]        i_b;
    logic               i_sub;
    logic               o_valid;
    logic               i_ready;
    logic               o_sign;
    logic [FP_EXP_W-1:0] o_exp;
    logic [ALIGN_W-1:0] o_mant_l;
    logic [ALIGN_W-1:0] o_mant_s;
    logic               o_eff_sub;
    logic               o_nan;
    logic               o_inf;
    logic               o_zero;

    // Pipeline stage view
    modport slave (
        input  i_valid, i_a, i_b, i_sub, i_ready,
        output o_ready, o_valid, o_sign, o_exp, o_mant_l, o_mant_s,
               o_eff_sub, o_nan, o_inf, o_zero
    );

    // Upstream producer / downstream consumer view
    modport master (
        output i_valid, i_a, i_b, i_sub, i_ready,
        input  o_ready, o_valid, o_sign, o_exp, o_mant_l, o_mant_s,
               o_eff_sub, o_nan, o_inf, o_zero
    );

endinterface

// File: rtl/fp_align_shift.sv
// Combinational right shifter for the smaller mantissa; every bit shifted
// out is ORed into the LSB so rounding downstream sees a correct sticky.
module fp_align_shift
    import fp_add_align_pkg::*;
(
    input  logic [FP_MAN_W:0]   mant,
    input  logic [DIFF_W-1:0]   d,
    output logic [ALIGN_W-1:0]  aligned
);

    logic [ALIGN_W-1:0] ext_s;
    logic [ALIGN_W-1:0] shifted_s;
    logic [ALIGN_W-1:0] lost_mask_s;
    logic               sticky_s;

    // Shift with sticky; shifts past the full width collapse to sticky only
    always_comb begin
        ext_s       = {mant, 3'b000};
        lost_mask_s = ~({ALIGN_W{1'b1}} << d[4:0]);
        shifted_s   = ext_s >> d[4:0];
        sticky_s    = |(ext_s & lost_mask_s);
        if (d >= 9'd27) begin
            aligned = {{(ALIGN_W-1){1'b0}}, |mant};
        end else begin
            aligned = {shifted_s[ALIGN_W-1:1], shifted_s[0] | sticky_s};
        end
    end

endmodule

// File: rtl/fp_add_align.sv
// Two-stage FP32 add/sub pre-alignment: S1 orders operands by magnitude and
// computes the exponent difference, S2 registers the aligned smaller mantissa.
module fp_add_align
    import fp_add_align_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic          i_clk,
    input  logic          i_reset,
    fp_add_align_if.slave bus
);

    fp_unpacked_t       a_u_s;
    fp_unpacked_t       b_u_s;
    logic [EXP_W:0]     diff_ab_s;
    logic [MAN_W:0]     mant_l_s;
    logic [MAN_W:0]     mant_s_s;
    logic               swap_s;
    logic               advance_s;
    logic               eff_sub_s;
    logic               a_nan_s;
    logic               a_inf_s;
    logic               b_nan_s;
    logic               b_inf_s;
    logic               nan_s;
    logic [ALIGN_W-1:0] shift_out_s;

    logic v1_d;
    logic v1_q;
    logic o_valid_d;
    logic o_valid_q;
    s1_t  s1_d;
    s1_t  s1_q;
    s2_t  s2_d;
    s2_t  s2_q;

    // Whole pipe moves together unless a result is waiting on downstream
    assign advance_s   = !o_valid_q || bus.i_ready;
    assign bus.o_ready = advance_s;

    // S1 next state: unpack, magnitude swap, exponent difference, special flags
    always_comb begin
        a_u_s     = fp_unpack(bus.i_a, 1'b0);
        b_u_s     = fp_unpack(bus.i_b, bus.i_sub);
        diff_ab_s = {1'b0, a_u_s.exp} - {1'b0, b_u_s.exp};
        // Borrow means b has the larger exponent; on a tie the mantissas decide
        swap_s    = diff_ab_s[EXP_W] |
                    ((diff_ab_s == 9'd0) & (b_u_s.mant > a_u_s.mant));
        mant_l_s  = swap_s ? b_u_s.mant : a_u_s.mant;
        mant_s_s  = swap_s ? a_u_s.mant : b_u_s.mant;
        a_nan_s   = fp_is_nan(bus.i_a);
        b_nan_s   = fp_is_nan(bus.i_b);
        a_inf_s   = fp_is_inf(bus.i_a);
        b_inf_s   = fp_is_inf(bus.i_b);
        eff_sub_s = bus.i_a[FP_SIGN_BIT] ^ bus.i_b[FP_SIGN_BIT] ^ bus.i_sub;
        nan_s     = a_nan_s | b_nan_s | (a_inf_s & b_inf_s & eff_sub_s);
        v1_d      = v1_q;
        s1_d      = s1_q;
        if (advance_s) begin
            v1_d         = bus.i_valid;
            s1_d.sign    = swap_s ? b_u_s.sign : a_u_s.sign;
            s1_d.exp     = swap_s ? b_u_s.exp : a_u_s.exp;
            s1_d.mant_l  = mant_l_s;
            s1_d.mant_s  = mant_s_s;
            s1_d.d       = swap_s ? (9'd0 - diff_ab_s) : diff_ab_s;
            s1_d.eff_sub = eff_sub_s;
            s1_d.nan     = nan_s;
            // A lone Inf is always the larger operand, so its sign is already in s1 sign
            s1_d.inf     = (a_inf_s | b_inf_s) & !nan_s;
            s1_d.zero    = fp_is_zero(bus.i_a) & fp_is_zero(bus.i_b);
        end else begin
            v1_d = v1_q;
            s1_d = s1_q;
        end
    end

    fp_align_shift u_shift (
        .mant    (s1_q.mant_s),
        .d       (s1_q.d),
        .aligned (shift_out_s)
    );

    // S2 next state: register the aligned mantissas; bubbles pass as o_valid = 0
    always_comb begin
        o_valid_d = o_valid_q;
        s2_d      = s2_q;
        if (advance_s) begin
            o_valid_d    = v1_q;
            s2_d.sign    = s1_q.sign;
            s2_d.exp     = s1_q.exp;
            s2_d.mant_l  = {s1_q.mant_l, 3'b000};
            s2_d.mant_s  = shift_out_s;
            s2_d.eff_sub = s1_q.eff_sub;
            s2_d.nan     = s1_q.nan;
            s2_d.inf     = s1_q.inf;
            s2_d.zero    = s1_q.zero;
        end else begin
            o_valid_d = o_valid_q;
            s2_d      = s2_q;
        end
    end

    // Pipeline registers; reset discards anything in flight
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            v1_q      <= 1'b0;
            s1_q      <= '0;
            o_valid_q <= 1'b0;
            s2_q      <= '0;
        end else begin
            v1_q      <= v1_d;
            s1_q      <= s1_d;
            o_valid_q <= o_valid_d;
            s2_q      <= s2_d;
        end
    end

    assign bus.o_valid   = o_valid_q;
    assign bus.o_sign    = s2_q.sign;
    assign bus.o_exp     = s2_q.exp;
    assign bus.o_mant_l  = s2_q.mant_l;
    assign bus.o_mant_s  = s2_q.mant_s;
    assign bus.o_eff_sub = s2_q.eff_sub;
    assign bus.o_nan     = s2_q.nan;
    assign bus.o_inf     = s2_q.inf;
    assign bus.o_zero    = s2_q.zero;

endmodule

// File: tb/tb_fp_add_align.sv
// Scoreboard bench for fp_add_align: a driver pushes model results on accept,
// a negedge monitor pops and compares whenever a result is handed downstream.
module tb_fp_add_align;
    import fp_add_align_pkg::*;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [26:0] mant_l;
        logic [26:0] mant_s;
        logic        eff_sub;
        logic        nan;
        logic        inf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    res_t exp_q[$];
    res_t snap;
    logic stalled = 1'b0;

    fp_add_align_if bus();

    fp_add_align dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic res_t cur_out();
        res_t r;
        r = {bus.o_sign, bus.o_exp, bus.o_mant_l, bus.o_mant_s,
             bus.o_eff_sub, bus.o_nan, bus.o_inf, bus.o_zero};
        return r;
    endfunction

    // Reference: order by raw magnitude word, shift with plain integer arithmetic
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        res_t        r;
        logic [31:0] l;
        logic [31:0] s;
        logic        swap;
        logic        an, ai, bn, bi;
        logic [23:0] ml, ms;
        int          el, es, d;
        longint      ext, q;
        swap = (b[30:0] > a[30:0]);
        l = swap ? b : a;
        s = swap ? a : b;
        r.sign = swap ? (b[31] ^ sub) : a[31];
        el = (l[30:23] == 8'h00) ? 1 : int'(l[30:23]);
        es = (s[30:23] == 8'h00) ? 1 : int'(s[30:23]);
        ml = {l[30:23] != 8'h00, l[22:0]};
        ms = {s[30:23] != 8'h00, s[22:0]};
        r.exp = el[7:0];
        r.mant_l = {ml, 3'b000};
        d = el - es;
        ext = longint'(ms) * 8;
        if (d >= 27) begin
            r.mant_s = (ms != 24'h0) ? 27'd1 : 27'd0;
        end else begin
            q = ext >> d;
            if ((q << d) != ext) q = q | 64'd1;
            r.mant_s = q[26:0];
        end
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        r.eff_sub = a[31] ^ b[31] ^ sub;
        r.nan = an | bn | (ai & bi & r.eff_sub);
        r.inf = (ai | bi) & !r.nan;
        r.zero = (a[30:0] == 31'h0) && (b[30:0] == 31'h0);
        return r;
    endfunction

    function automatic logic [31:0] rand_op(input logic [31:0] ref_op);
        logic [31:0] x;
        int          k;
        x = $urandom;
        k = $urandom_range(0, 7);
        case (k)
            2: x[30:0] = {8'hFF, 23'h0};
            3: x[30:23] = 8'hFF;
            4: x[30:0] = 31'h0;
            5: x[30:23] = 8'h00;
            6, 7: x[30:23] = ref_op[30:23] - 8'($urandom_range(0, 30));
            default: x = x;
        endcase
        return x;
    endfunction

    task automatic drive_cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic rdy, output logic acc);
        @(posedge clk);
        #1;
        bus.i_valid = v;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_sub   = sub;
        bus.i_ready = rdy;
        #1;
        acc = v && bus.o_ready;
        if (acc) exp_q.push_back(model(a, b, sub));
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input int rdy_pct);
        logic acc;
        int   n;
        n = 0;
        do begin
            drive_cycle(1'b1, a, b, sub, ($urandom_range(0, 99) < rdy_pct), acc);
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: operand pair %h/%h never accepted", a, b);
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        repeat (n) drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, rdy, acc);
    endtask

    // Monitor: handshake rule, stall stability, in-order scoreboard pop
    always @(negedge clk) begin
        if (rst) begin
            stalled <= 1'b0;
        end else begin
            check("o_ready", bus.o_ready, !bus.o_valid || bus.i_ready);
            if (stalled) check("stall_hold", cur_out(), snap);
            if (bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_output: got %h with nothing expected", cur_out());
                end else begin
                    check("result", cur_out(), exp_q.pop_front());
                end
            end
            stalled <= bus.o_valid && !bus.i_ready;
            snap    <= cur_out();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, prev;
        logic        acc;
        bus.i_valid = 1'b0;
        bus.i_a     = 32'h0;
        bus.i_b     = 32'h0;
        bus.i_sub   = 1'b0;
        bus.i_ready = 1'b1;
        #3;
        check("reset_o_valid", bus.o_valid, 1'b0);
        check("reset_o_ready", bus.o_ready, 1'b1);
        check("reset_outputs", cur_out(), 80'd0);
        #20 rst = 1'b0;

        // Directed cases
        send(32'h3F800000, 32'h3F800000, 1'b0, 100);
        send(32'h3F800000, 32'h3FC00000, 1'b1, 100);
        send(32'h3F800000, 32'h3D800001, 1'b0, 100);
        send(32'h3F800000, 32'h30800000, 1'b0, 100);
        send(32'h7F800000, 32'h7F800000, 1'b1, 100);
        send(32'h7F800000, 32'h3F800000, 1'b0, 100);
        send(32'h00000000, 32'h80000000, 1'b0, 100);
        send(32'h00000001, 32'h00800000, 1'b1, 100);
        send(32'hFF800000, 32'h7FC00000, 1'b0, 100);
        idle(4, 1'b1);

        // Three back-to-back with downstream stalled in cycles 3..5
        drive_cycle(1'b1, 32'h40000000, 32'h3F000000, 1'b0, 1'b1, acc);
        drive_cycle(1'b1, 32'h41200000, 32'hC0400000, 1'b1, 1'b1, acc);
        for (int k = 3; k < 20; k++) begin
            drive_cycle(1'b1, 32'h3E800000, 32'h42C80000, 1'b0, !(k >= 3 && k <= 5), acc);
            if (k >= 3 && k <= 5) check("stall_o_ready", bus.o_ready, 1'b0);
            if (acc) break;
        end
        idle(2, 1'b0);
        idle(4, 1'b1);
        check("stall_drain", exp_q.size(), 0);

        // Randomized traffic with random downstream backpressure
        prev = 32'h3F800000;
        for (int i = 0; i < 300; i++) begin
            a = rand_op(prev);
            b = rand_op(a);
            send(a, b, 1'($urandom_range(0, 1)), 70);
            prev = a;
            if ($urandom_range(0, 7) == 0) idle(1, 1'($urandom_range(0, 1)));
        end
        idle(10, 1'b1);

        // Asynchronous reset with two operations in flight
        send(32'h3F800000, 32'h40400000, 1'b0, 100);
        send(32'h40A00000, 32'h3F800000, 1'b1, 100);
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async_reset_o_valid", bus.o_valid, 1'b0);
        check("async_reset_o_ready", bus.o_ready, 1'b1);
        check("async_reset_outputs", cur_out(), 80'd0);
        exp_q.delete();
        #10 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_reset_idle", bus.o_valid, 1'b0);
        end
        send(32'h3F800000, 32'h3F800000, 1'b0, 100);
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        @(negedge clk);
        check("latency_cycle1", bus.o_valid, 1'b0);
        @(negedge clk);
        check("latency_cycle2", bus.o_valid, 1'b1);
        idle(4, 1'b1);
        check("final_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
